// File: rtl/sddt_cmd_dispatcher.sv
// sddt_cmd_dispatcher: routes one AXI-Stream command channel into NUM_CH
// first-word-fall-through FIFOs using the 8-bit channel field of each beat.
// Beats aimed at a missing channel are dropped and counted. The forward and
// drop statistics are packed into a GPIO status word.
module sddt_cmd_dispatcher #(
    parameter int unsigned DATA_WIDTH = 128,
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned CH_SEL_LSB = 120,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned CNT_WIDTH  = 16,
    localparam int unsigned AW        = $clog2(FIFO_DEPTH)
) (
    input  logic                         axi_aclk,
    input  logic                         axi_aresetn,
    input  logic [DATA_WIDTH-1:0]        S_AXIS_CMD_tdata,
    input  logic                         S_AXIS_CMD_tvalid,
    output logic                         S_AXIS_CMD_tready,
    output logic [NUM_CH*DATA_WIDTH-1:0] M_AXIS_CMD_tdata,
    output logic [NUM_CH-1:0]            M_AXIS_CMD_tvalid,
    input  logic [NUM_CH-1:0]            M_AXIS_CMD_tready,
    input  logic                         stat_clr,
    output logic [NUM_CH*(AW+1)-1:0]     fifo_level,
    output logic [CNT_WIDTH-1:0]         fwd_cnt,
    output logic [CNT_WIDTH-1:0]         drop_cnt,
    output logic [31:0]                  gpio_out
);

    localparam logic [8:0] NUM_CH_W = 9'(NUM_CH);

    logic                  run_q;
    logic [DATA_WIDTH-1:0] mem_q    [NUM_CH][FIFO_DEPTH];
    logic [AW:0]           wr_ptr_q [NUM_CH];
    logic [AW:0]           wr_ptr_d [NUM_CH];
    logic [AW:0]           rd_ptr_q [NUM_CH];
    logic [AW:0]           rd_ptr_d [NUM_CH];
    logic [CNT_WIDTH-1:0]  fwd_cnt_q, fwd_cnt_d;
    logic [CNT_WIDTH-1:0]  drop_cnt_q, drop_cnt_d;
    logic                  sticky_q, sticky_d;

    logic [7:0]            ch;
    logic                  ch_ok;
    logic                  sel_full;
    logic                  accept;
    logic [NUM_CH-1:0]     full, empty, push, pop;

    // Run flag: low during reset, high from the first edge that samples reset released.
    always_ff @(posedge axi_aclk) begin
        if (!axi_aresetn) run_q <= 1'b0;
        else              run_q <= 1'b1;
    end

    // Channel decode, FIFO status and input handshake. The full flag of the
    // addressed channel is picked with a loop so an out-of-range channel
    // number never indexes past the array.
    always_comb begin
        ch       = S_AXIS_CMD_tdata[CH_SEL_LSB +: 8];
        ch_ok    = ({1'b0, ch} < NUM_CH_W);
        sel_full = 1'b0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            full[k]  = (wr_ptr_q[k][AW] != rd_ptr_q[k][AW]) &&
                       (wr_ptr_q[k][AW-1:0] == rd_ptr_q[k][AW-1:0]);
            empty[k] = (wr_ptr_q[k] == rd_ptr_q[k]);
            if (ch == 8'(k)) sel_full = full[k];
        end
        S_AXIS_CMD_tready = run_q & (~ch_ok | ~sel_full);
        accept            = S_AXIS_CMD_tvalid & S_AXIS_CMD_tready;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            push[k] = accept & ch_ok & (ch == 8'(k));
            pop[k]  = ~empty[k] & M_AXIS_CMD_tready[k];
        end
    end

    // Next pointers, per-channel outputs and occupancy.
    always_comb begin
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            wr_ptr_d[k] = wr_ptr_q[k] + {{AW{1'b0}}, push[k]};
            rd_ptr_d[k] = rd_ptr_q[k] + {{AW{1'b0}}, pop[k]};
            M_AXIS_CMD_tvalid[k]                      = ~empty[k];
            M_AXIS_CMD_tdata[k*DATA_WIDTH +: DATA_WIDTH] = mem_q[k][rd_ptr_q[k][AW-1:0]];
            fifo_level[k*(AW+1) +: AW+1]              = wr_ptr_q[k] - rd_ptr_q[k];
        end
    end

    // FIFO pointer registers; reset empties every channel.
    always_ff @(posedge axi_aclk) begin
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (!axi_aresetn) begin
                wr_ptr_q[k] <= '0;
                rd_ptr_q[k] <= '0;
            end else begin
                wr_ptr_q[k] <= wr_ptr_d[k];
                rd_ptr_q[k] <= rd_ptr_d[k];
            end
        end
    end

    // FIFO storage; contents need no reset since empty pointers hide them.
    always_ff @(posedge axi_aclk) begin
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (push[k]) mem_q[k][wr_ptr_q[k][AW-1:0]] <= S_AXIS_CMD_tdata;
        end
    end

    // Statistics next state: forward count wraps, drop count saturates.
    always_comb begin
        fwd_cnt_d  = fwd_cnt_q + CNT_WIDTH'(accept & ch_ok);
        drop_cnt_d = drop_cnt_q;
        sticky_d   = sticky_q;
        if (accept && !ch_ok) begin
            sticky_d = 1'b1;
            if (!(&drop_cnt_q)) drop_cnt_d = drop_cnt_q + 1'b1;
        end
    end

    // Statistics registers; a clear pulse wins over a same-cycle event.
    always_ff @(posedge axi_aclk) begin
        if (!axi_aresetn || stat_clr) begin
            fwd_cnt_q  <= '0;
            drop_cnt_q <= '0;
            sticky_q   <= 1'b0;
        end else begin
            fwd_cnt_q  <= fwd_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            sticky_q   <= sticky_d;
        end
    end

    assign fwd_cnt  = fwd_cnt_q;
    assign drop_cnt = drop_cnt_q;
    assign gpio_out = {fwd_cnt_q[15:0], drop_cnt_q[7:0], 7'b0, sticky_q};

endmodule

// File: tb/tb_sddt_cmd_dispatcher.sv
// Directed self-checking bench for sddt_cmd_dispatcher (default parameters).
module tb_sddt_cmd_dispatcher;

    localparam int unsigned DW = 128;
    localparam int unsigned NC = 4;
    localparam int unsigned LW = 5;

    logic              clk = 1'b0;
    logic              rstn;
    logic [DW-1:0]     s_tdata;
    logic              s_tvalid;
    logic              s_tready;
    logic [NC*DW-1:0]  m_tdata;
    logic [NC-1:0]     m_tvalid;
    logic [NC-1:0]     m_tready;
    logic              stat_clr;
    logic [NC*LW-1:0]  fifo_level;
    logic [15:0]       fwd_cnt;
    logic [15:0]       drop_cnt;
    logic [31:0]       gpio_out;

    int n_cmp = 0;
    int n_err = 0;
    int e0 = 0;
    int e2 = 0;
    logic mon_done = 1'b0;

    sddt_cmd_dispatcher #(
        .DATA_WIDTH (128),
        .NUM_CH     (4),
        .CH_SEL_LSB (120),
        .FIFO_DEPTH (16),
        .CNT_WIDTH  (16)
    ) dut (
        .axi_aclk          (clk),
        .axi_aresetn       (rstn),
        .S_AXIS_CMD_tdata  (s_tdata),
        .S_AXIS_CMD_tvalid (s_tvalid),
        .S_AXIS_CMD_tready (s_tready),
        .M_AXIS_CMD_tdata  (m_tdata),
        .M_AXIS_CMD_tvalid (m_tvalid),
        .M_AXIS_CMD_tready (m_tready),
        .stat_clr          (stat_clr),
        .fifo_level        (fifo_level),
        .fwd_cnt           (fwd_cnt),
        .drop_cnt          (drop_cnt),
        .gpio_out          (gpio_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] mk(input logic [7:0] ch, input logic [15:0] pl);
        logic [DW-1:0] b;
        b = '0;
        b[127:120] = ch;
        b[15:0]    = pl;
        return b;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rstn     = 1'b0;
        s_tdata  = '0;
        s_tvalid = 1'b0;
        m_tready = '1;
        stat_clr = 1'b0;

        // Reset and idle
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rst_tready", 64'(s_tready), 64'd0);
        end
        rstn = 1'b1;
        #1;
        check("pre_release_tready", 64'(s_tready), 64'd0);
        tick();
        check("post_release_tready", 64'(s_tready), 64'd1);
        check("idle_tvalid", 64'(m_tvalid), 64'd0);
        check("idle_gpio", 64'(gpio_out), 64'd0);

        // Routing: ch 0..3, payload A0..A3
        for (int i = 0; i < 4; i++) begin
            s_tdata  = mk(8'(i), 16'(8'hA0 + i));
            s_tvalid = 1'b1;
            #1;
            check("route_tready", 64'(s_tready), 64'd1);
            tick();
            check("route_tvalid", 64'(m_tvalid), 64'(4'b0001 << i));
            check("route_data", 64'(m_tdata[i*DW +: 8]), 64'(8'hA0 + i));
        end
        s_tvalid = 1'b0;
        check("route_fwd", 64'(fwd_cnt), 64'd4);
        tick();
        check("route_drained", 64'(m_tvalid), 64'd0);

        // Drop: three beats to channel 7
        for (int i = 0; i < 3; i++) begin
            s_tdata  = mk(8'h07, 16'h00EE);
            s_tvalid = 1'b1;
            #1;
            check("drop_tready", 64'(s_tready), 64'd1);
            tick();
            check("drop_tvalid", 64'(m_tvalid), 64'd0);
        end
        s_tvalid = 1'b0;
        check("drop_cnt", 64'(drop_cnt), 64'd3);
        check("drop_gpio", 64'(gpio_out), 64'h0004_0301);
        s_tdata  = mk(8'h07, 16'h00EF);
        s_tvalid = 1'b1;
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        s_tvalid = 1'b0;
        check("clr_drop_cnt", 64'(drop_cnt), 64'd0);
        check("clr_gpio", 64'(gpio_out), 64'd0);

        // Full and back-pressure on ch 1
        m_tready = 4'b1101;
        for (int i = 0; i < 16; i++) begin
            s_tdata  = mk(8'h01, 16'(i));
            s_tvalid = 1'b1;
            #1;
            check("fill_tready", 64'(s_tready), 64'd1);
            tick();
        end
        s_tdata = mk(8'h01, 16'd16);
        #1;
        check("full_tready", 64'(s_tready), 64'd0);
        check("full_level", 64'(fifo_level[1*LW +: LW]), 64'd16);
        m_tready[1] = 1'b1;
        tick();
        m_tready[1] = 1'b0;
        check("pop_level", 64'(fifo_level[1*LW +: LW]), 64'd15);
        check("pop_tready", 64'(s_tready), 64'd1);
        check("pop_fwd", 64'(fwd_cnt), 64'd16);
        tick();
        check("refill_level", 64'(fifo_level[1*LW +: LW]), 64'd16);
        check("refill_fwd", 64'(fwd_cnt), 64'd17);
        s_tvalid = 1'b0;
        m_tready = '1;
        for (int j = 1; j <= 16; j++) begin
            check("drain_valid", 64'(m_tvalid[1]), 64'd1);
            check("drain_data", 64'(m_tdata[1*DW +: 16]), 64'(j));
            tick();
        end
        check("drain_empty", 64'(m_tvalid[1]), 64'd0);

        // Wrap and concurrency: ch 0 and ch 2 interleaved, 100 beats each
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        fork
            begin : driver
                for (int i = 0; i < 200; i++) begin
                    int w;
                    s_tdata  = mk((i % 2 == 1) ? 8'h02 : 8'h00, 16'(i / 2));
                    s_tvalid = 1'b1;
                    #1;
                    w = 0;
                    while (!s_tready && w < 1000) begin
                        tick();
                        #1;
                        w++;
                    end
                    if (w >= 1000) check("drv_timeout", 64'd1, 64'd0);
                    @(posedge clk);
                    #1;
                end
                s_tvalid = 1'b0;
            end
            begin : monitor
                int cyc;
                cyc = 0;
                while ((e0 < 100 || e2 < 100) && cyc < 5000) begin
                    @(negedge clk);
                    if (m_tvalid[0] && m_tready[0]) begin
                        check("wrap_ch0", 64'(m_tdata[0*DW +: 16]), 64'(e0));
                        e0++;
                    end
                    if (m_tvalid[2] && m_tready[2]) begin
                        check("wrap_ch2", 64'(m_tdata[2*DW +: 16]), 64'(e2));
                        e2++;
                    end
                    cyc++;
                end
                mon_done = 1'b1;
            end
            begin : toggler
                while (!mon_done) begin
                    @(posedge clk);
                    #1;
                    if (!mon_done) m_tready[2] = 1'($urandom_range(0, 1));
                end
                m_tready[2] = 1'b1;
            end
        join
        tick();
        check("wrap_cnt0", 64'(e0), 64'd100);
        check("wrap_cnt2", 64'(e2), 64'd100);
        check("wrap_fwd", 64'(fwd_cnt), 64'd200);
        check("wrap_idle", 64'(m_tvalid), 64'd0);
        check("wrap_level", 64'(fifo_level), 64'd0);

        // Mid-stream reset with 5 beats queued on ch 3
        m_tready = 4'b0111;
        for (int i = 0; i < 5; i++) begin
            s_tdata  = mk(8'h03, 16'(16'h300 + i));
            s_tvalid = 1'b1;
            tick();
        end
        s_tvalid = 1'b0;
        check("queued_level", 64'(fifo_level[3*LW +: LW]), 64'd5);
        rstn = 1'b0;
        tick();
        check("mrst_tvalid", 64'(m_tvalid), 64'd0);
        check("mrst_level", 64'(fifo_level), 64'd0);
        check("mrst_tready", 64'(s_tready), 64'd0);
        check("mrst_gpio", 64'(gpio_out), 64'd0);
        rstn = 1'b1;
        tick();
        m_tready = '1;
        s_tdata  = mk(8'h03, 16'h005A);
        s_tvalid = 1'b1;
        #1;
        check("after_rst_tready", 64'(s_tready), 64'd1);
        tick();
        s_tvalid = 1'b0;
        check("after_rst_tvalid", 64'(m_tvalid), 64'b1000);
        check("after_rst_data", 64'(m_tdata[3*DW +: 16]), 64'h005A);
        check("after_rst_fwd", 64'(fwd_cnt), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
